// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
//
// Encoder counterpart of the control-unit decoder. It accepts instruction
// field bundles from the loader source, packs each bundle into a 32-bit RV32I
// word, and writes the words into instruction memory at consecutive word
// addresses, starting at base_addr.
//
// State table:
//   state  | meaning
//   IDLE   | after reset; no load active, in_ready=0
//   LOAD   | accepting bundles, one imem write per accepted bundle
//   DONE   | load finished (in_last seen, address space exhausted, or
//          | base_addr out of range); in_ready=0, waits for start
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, base_addr          begin (or restart) a load at base_addr
//   in_valid/in_ready/in_last bundle handshake and end-of-program marker
//   in_class, in_f3, in_f7b,
//   in_rd, in_rs1, in_rs2,
//   in_imm                    instruction fields (in_imm: signed, byte units)
//   imem_we/addr/wdata        imem write port
//   busy, done                FSM in LOAD / FSM in DONE
//   full                      sticky: stopped at the end of the address space
//   err                       sticky: an illegal or out-of-range bundle was
//                             replaced by a NOP
// -----------------------------------------------------------------------------
module instr_encoder_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        in_class,
    input  logic [2:0]        in_f3,
    input  logic              in_f7b,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [20:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] CLS_R   = 3'd0;
    localparam logic [2:0] CLS_I   = 3'd1;
    localparam logic [2:0] CLS_LW  = 3'd2;
    localparam logic [2:0] CLS_SW  = 3'd3;
    localparam logic [2:0] CLS_BEQ = 3'd4;
    localparam logic [2:0] CLS_JAL = 3'd5;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // One extra bit so base_addr can be compared against DEPTH even when
    // DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0]   DEPTH_X   = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              we_q;

    logic [31:0] enc_word;
    logic        enc_bad;
    logic        imm_fits12;
    logic        imm_fits13;
    logic        is_shift;
    logic        base_oob;
    logic        accept;

    // -------------------------------------------------------------------------
    // Field packing and legality check
    // -------------------------------------------------------------------------
    assign imm_fits12 = (in_imm[20:11] == {10{in_imm[11]}});
    assign imm_fits13 = (in_imm[20:12] == {9{in_imm[12]}});
    assign is_shift   = (in_f3 == 3'b001) || (in_f3 == 3'b101);

    always_comb begin
        enc_word = NOP_WORD;
        enc_bad  = 1'b0;
        case (in_class)
            CLS_R: begin
                enc_word = {1'b0, in_f7b, 5'b00000, in_rs2, in_rs1, in_f3, in_rd, OP_R};
            end
            CLS_I: begin
                if (is_shift) begin
                    // Shift-immediate: shamt in imm[4:0], SRAI selected by f7b.
                    enc_bad  = (in_imm[20:5] != '0);
                    enc_word = {1'b0, in_f7b, 5'b00000, in_imm[4:0], in_rs1, in_f3, in_rd, OP_I};
                end else begin
                    enc_bad  = !imm_fits12;
                    enc_word = {in_imm[11:0], in_rs1, in_f3, in_rd, OP_I};
                end
            end
            CLS_LW: begin
                enc_bad  = !imm_fits12;
                enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LW};
            end
            CLS_SW: begin
                enc_bad  = !imm_fits12;
                enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OP_SW};
            end
            CLS_BEQ: begin
                enc_bad  = !imm_fits13 || in_imm[0];
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                            in_imm[4:1], in_imm[11], OP_BR};
            end
            CLS_JAL: begin
                enc_bad  = in_imm[0];
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
            end
            default: begin
                enc_bad = 1'b1;
            end
        endcase
        // Bad bundles still occupy their slot so the program layout is kept.
        if (enc_bad) begin
            enc_word = NOP_WORD;
        end
    end

    // -------------------------------------------------------------------------
    // Load sequencer
    // -------------------------------------------------------------------------
    assign base_oob = ({1'b0, base_addr} >= DEPTH_X);

    // start wins over a bundle offered in the same cycle: the restart
    // repositions the pointer and that bundle is not taken.
    assign accept = (state == S_LOAD) && in_valid && !start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ptr        <= '0;
            we_q       <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            full       <= 1'b0;
            err        <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (start) begin
                ptr <= base_addr;
                err <= 1'b0;
                if (base_oob) begin
                    state    <= S_DONE;
                    full     <= 1'b1;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                end else begin
                    state    <= S_LOAD;
                    full     <= 1'b0;
                    in_ready <= 1'b1;
                    busy     <= 1'b1;
                    done     <= 1'b0;
                end
            end else if (accept) begin
                we_q       <= 1'b1;
                imem_addr  <= ptr;
                imem_wdata <= enc_word;
                ptr        <= ptr + 1'b1;
                if (enc_bad) begin
                    err <= 1'b1;
                end
                // The write to the last word ends the load; in_ready drops in
                // the same cycle the write is presented.
                if (in_last || (ptr == LAST_ADDR)) begin
                    state    <= S_DONE;
                    full     <= !in_last;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                end
            end
        end
    end

    // Reset squashes a write already registered for this cycle, so a reset
    // arriving right after an accept produces no write at all.
    assign imem_we = we_q && !rst;

endmodule
